// File: rtl/vload_stream.sv
// ============================================================================
// Module      : vload_stream
// Description : Vector load sequencer; streams word jobs from the data ROM as
//               masked 6-lane beats over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vload_stream #(
    parameter int S     = 32,
    parameter int LANES = 6,
    parameter int V     = 192,
    parameter int SIZE  = 30015
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [S-1:0]     base_addr,
    input  logic [S-1:0]     count,
    output logic [S-1:0]     rom_addr,
    input  logic [V-1:0]     rom_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [V-1:0]     out_data,
    output logic [LANES-1:0] out_mask,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [S-1:0] c_lanes = S'(LANES);
    localparam logic [S:0]   c_size  = (S+1)'(SIZE);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [S-1:0]     r_ptr;
    logic [S-1:0]     r_remaining;
    logic [V-1:0]     r_data;
    logic [LANES-1:0] r_mask;
    logic             r_last;

    logic             w_accept;
    logic             w_load;
    logic [S-1:0]     w_take;
    logic             w_beat_last;
    logic [LANES-1:0] w_valid;
    logic [V-1:0]     w_beat_data;

    assign w_accept    = (r_state == IDLE) && start && (count != '0);
    assign w_load      = (r_state == FETCH) ||
                         ((r_state == HOLD) && out_ready && !r_last);
    assign w_take      = (r_remaining < c_lanes) ? r_remaining : c_lanes;
    assign w_beat_last = (r_remaining <= c_lanes);

    // Lane address is widened by one bit so a pointer wrap can never look in range.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [S-1:0] c_idx = S'(i);
        logic [S:0] w_lane_addr;

        assign w_lane_addr = {1'b0, r_ptr} + {1'b0, c_idx};
        assign w_valid[i]  = (c_idx < r_remaining) && (w_lane_addr < c_size);
        assign w_beat_data[S*i +: S] = w_valid[i] ? rom_rd[S*i +: S] : '0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (count != '0) ? FETCH : DONE;
                end
            end
            FETCH: w_next_state = HOLD;
            HOLD: begin
                if (out_ready && r_last) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            IDLE:  ;
            FETCH: busy = 1'b1;
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Job pointer, word budget and the registered beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_last      <= 1'b0;
        end else if (w_accept) begin
            r_ptr       <= base_addr;
            r_remaining <= count;
        end else if (w_load) begin
            r_data      <= w_beat_data;
            r_mask      <= w_valid;
            r_last      <= w_beat_last;
            r_ptr       <= r_ptr + c_lanes;
            r_remaining <= r_remaining - w_take;
        end
    end

    assign rom_addr = r_ptr;
    assign out_data = r_data;
    assign out_mask = r_mask;
    assign out_last = r_last;

endmodule

`default_nettype wire

// File: doc/vload_stream.md
# vload_stream

Vector load sequencer sitting directly upstream of the data-memory ROM. Each job streams `count` consecutive 32-bit words from word address `base_addr`, one 192-bit vector (6 lanes) per beat. It drives the ROM address, registers the combinational 192-bit read, and presents each beat to the vector datapath through a valid/ready handshake with a per-lane mask and a last flag.

## Interface
- S, 32: word width and address width.
- LANES, 6: words per vector beat.
- V, 192: vector width; must equal S*LANES.
- SIZE, 30015: ROM depth in words; lane addresses >= SIZE are out of range.

- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- base_addr  in  S  first word address, latched on accepted start.
- count  in  S  number of words in job, latched on accepted start.
- rom_addr  out  S  word address to ROM (lane 0); ROM returns words rom_addr..rom_addr+5 combinationally.
- rom_rd  in  V  ROM read data; lane i = bits [S*i+S-1 : S*i].
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat when out_valid && out_ready.
- out_data  out  V  registered beat data; invalid lanes forced to 0.
- out_mask  out  LANES  bit i = lane i holds a real word.
- out_last  out  1  current beat is final beat of job.
- busy  out  1  high in FETCH, HOLD, DONE.
- done  out  1  one-cycle pulse at job end.

## Operation
- Registers: ptr (S bits), remaining (S bits), out_data/out_mask/out_last.
- rom_addr = ptr at all times (also in IDLE).
- States: IDLE, FETCH, HOLD, DONE.
- IDLE: start && count!=0 -> ptr<=base_addr, remaining<=count, go FETCH. start && count==0 -> go DONE (no beats). start ignored in every other state.
- Beat load (in FETCH, or in HOLD on handshake when !out_last): for lane i, valid_i = (i < remaining) && (ptr+i < SIZE); out_data lane i <= valid_i ? rom_rd lane i : 0; out_mask[i] <= valid_i; out_last <= (remaining <= LANES); ptr <= ptr+LANES; remaining <= remaining - min(LANES, remaining). FETCH -> HOLD.
- HOLD: out_valid=1. No handshake -> out_data/out_mask/out_last/ptr/remaining held stable. Handshake && !out_last -> load next beat, stay HOLD (back-to-back beats). Handshake && out_last -> DONE.
- DONE: done=1 for exactly one cycle, -> IDLE.
- out_valid is high only in HOLD.
- remaining arithmetic is unsigned, never wraps below 0; ptr+i computed at S+1 bits so wrap never yields false in-range.
- reset (any state, including mid-job with beat pending): state<=IDLE, ptr/remaining<=0, out_data<=0, out_mask<=0, out_last<=0. Pending beat is dropped; no done pulse.

## Timing
- Reset values: rom_addr=0, out_valid=0, out_data=0, out_mask=0, out_last=0, busy=0, done=0.
- start accepted at edge N -> FETCH during cycle N+1 (rom_addr=base_addr) -> out_valid high from cycle N+2.
- With out_ready held high: one beat per cycle; job of B beats occupies HOLD for B cycles; done in cycle after final handshake.
- count==0: done in cycle N+1, out_valid never asserts.
- New start earliest in cycle after done (IDLE).
- out_ready low may be held indefinitely; outputs stable while out_valid && !out_ready.

## Test plan
- base_addr=0, count=12, out_ready=1 -> 2 beats on consecutive cycles, beat0 = words 0-5 mask 111111 last=0, beat1 = words 6-11 mask 111111 last=1, done pulse next cycle.
- base_addr=100, count=7 -> beat0 words 100-105 mask 111111; beat1 lane0 = word 106, lanes1-5 = 0, mask 000001, last=1.
- base_addr=0, count=18, out_ready toggling 1,0,0,1,... -> out_data/out_mask stable across stall cycles, all 18 words delivered in order exactly once.
- base_addr=30012, count=6 -> single beat, lanes 0-2 = words 30012-30014, lanes 3-5 = 0, mask 000111, last=1.
- start with count=0 -> done one cycle later, out_valid stays 0; start pulsed during HOLD of another job -> ignored.
- reset asserted in HOLD with beat pending -> next cycle out_valid=0, busy=0, done=0, rom_addr=0; fresh start afterwards runs normally.
